// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: pipeline/long-latency writeback inputs, scoreboard queries, regfile write port.
// slave = arbiter side, master = pipeline/regfile environment side.
interface wb_arbiter_if #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH     = 4
);
    logic                            pipe_wb_valid;
    logic [REG_ADDR_WIDTH-1:0]       pipe_wb_rd;
    logic [XLEN-1:0]                 pipe_wb_data;
    logic                            lu_valid;
    logic                            lu_ready;
    logic [REG_ADDR_WIDTH-1:0]       lu_rd;
    logic [XLEN-1:0]                 lu_data;
    logic                            issue_valid;
    logic [REG_ADDR_WIDTH-1:0]       issue_rd;
    logic [REG_ADDR_WIDTH-1:0]       rs1_addr;
    logic [REG_ADDR_WIDTH-1:0]       rs2_addr;
    logic                            rs1_busy;
    logic                            rs2_busy;
    logic                            rf_wr_en;
    logic [REG_ADDR_WIDTH-1:0]       rf_rd;
    logic [XLEN-1:0]                 rf_wdata;
    logic [$clog2(FIFO_DEPTH):0]     fifo_count;

    modport slave (
        input  pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
        input  lu_valid, lu_rd, lu_data,
        output lu_ready,
        input  issue_valid, issue_rd, rs1_addr, rs2_addr,
        output rs1_busy, rs2_busy,
        output rf_wr_en, rf_rd, rf_wdata, fifo_count
    );

    modport master (
        output pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
        output lu_valid, lu_rd, lu_data,
        input  lu_ready,
        output issue_valid, issue_rd, rs1_addr, rs2_addr,
        input  rs1_busy, rs2_busy,
        input  rf_wr_en, rf_rd, rf_wdata, fifo_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Merges pipeline writeback with buffered long-latency results onto one regfile write port; WB_SCOREBOARD_EN adds pending-rd tracking.
// Latency: 1 cycle select -> rf_*; FIFO result 2 cycles from accept at best.
// Backpressure: pipeline never stalls; long-latency side held off by lu_ready (deasserts when full).
module wb_arbiter #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic         clk,
    input  logic         reset,
    wb_arbiter_if.slave  bus
);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [XLEN-1:0]           data;
    } wb_entry_t;

    wb_entry_t          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    wb_entry_t          head;
    logic               push;
    logic               pop;

    // Full blocks a push even when a pop frees a slot in the same cycle.
    assign bus.lu_ready   = (count != CNT_W'(FIFO_DEPTH));
    assign bus.fifo_count = count;
    assign push           = bus.lu_valid && bus.lu_ready;
    assign pop            = !bus.pipe_wb_valid && (count != '0);
    assign head           = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{rd: bus.lu_rd, data: bus.lu_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rf_wr_en <= 1'b0;
            bus.rf_rd    <= '0;
            bus.rf_wdata <= '0;
        end else if (bus.pipe_wb_valid) begin
            bus.rf_wr_en <= (bus.pipe_wb_rd != '0);
            bus.rf_rd    <= bus.pipe_wb_rd;
            bus.rf_wdata <= bus.pipe_wb_data;
        end else if (pop) begin
            bus.rf_wr_en <= (head.rd != '0);
            bus.rf_rd    <= head.rd;
            bus.rf_wdata <= head.data;
        end else begin
            bus.rf_wr_en <= 1'b0;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] pending;

    // Set is applied after clear so a same-cycle issue to the popped rd stays pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            if (pop && (head.rd != '0)) pending[head.rd] <= 1'b0;
            if (bus.issue_valid && (bus.issue_rd != '0)) pending[bus.issue_rd] <= 1'b1;
        end
    end

    assign bus.rs1_busy = (bus.rs1_addr != '0) && pending[bus.rs1_addr];
    assign bus.rs2_busy = (bus.rs2_addr != '0) && pending[bus.rs2_addr];
`else
    logic unused_sb;
    assign unused_sb    = ^{bus.issue_valid, bus.issue_rd, bus.rs1_addr, bus.rs2_addr, NUM_REGS};
    assign bus.rs1_busy = 1'b0;
    assign bus.rs2_busy = 1'b0;
`endif
endmodule
